// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file with write-first bypass, an optional
// hardwired-zero entry 0 and a sequenced clear of all entries.
module reg_file_2r1w #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              RdEnA,
    input  logic [ADDR_W-1:0] RdAddrA,
    input  logic              RdEnB,
    input  logic [ADDR_W-1:0] RdAddrB,
    output logic [DATA_W-1:0] RdDataA,
    output logic [DATA_W-1:0] RdDataB,
    output logic              RdValidA,
    output logic              RdValidB,
    input  logic              ClrReq,
    output logic              Busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              busy_q;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic [1:0][DATA_W-1:0] rd_data_q, rd_data_d;
    logic [1:0]             rd_valid_q, rd_valid_d;
    logic [1:0]             rd_en;
    logic [1:0][ADDR_W-1:0] rd_addr;

    logic accept;
    logic wr_fire;

    // ClrReq wins over any access sampled in the same idle cycle.
    assign accept  = (state_q == ST_IDLE) && !ClrReq;
    assign wr_fire = accept && WrEn && !((ZERO_REG != 0) && (WrAddr == '0));

    assign rd_en   = {RdEnB, RdEnA};
    assign rd_addr = {RdAddrB, RdAddrA};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ClrReq) begin
                        state_q   <= ST_CLEAR;
                        busy_q    <= 1'b1;
                        clr_cnt_q <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_q == LAST_IDX) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (state_q == ST_CLEAR) begin
            mem_d[clr_cnt_q] = '0;
        end else if (wr_fire) begin
            mem_d[WrAddr] = WrData;
        end
    end

    // Write-first: a read of the address being written returns WrData.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = '0;
        for (int p = 0; p < 2; p++) begin
            if (accept && rd_en[p]) begin
                rd_valid_d[p] = 1'b1;
                if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
                    rd_data_d[p] = '0;
                end else if (wr_fire && (rd_addr[p] == WrAddr)) begin
                    rd_data_d[p] = WrData;
                end else begin
                    rd_data_d[p] = mem_q[rd_addr[p]];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign RdDataA  = rd_data_q[0];
    assign RdDataB  = rd_data_q[1];
    assign RdValidA = rd_valid_q[0];
    assign RdValidB = rd_valid_q[1];
    assign Busy     = busy_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Drives a plain and a ZERO_REG=1 instance with the same stimulus and checks
// both against an array-based reference model of the register file.
module tb_reg_file_2r1w;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        WrEn = 1'b0;
    logic [2:0]  WrAddr = '0;
    logic [15:0] WrData = '0;
    logic        RdEnA = 1'b0, RdEnB = 1'b0;
    logic [2:0]  RdAddrA = '0, RdAddrB = '0;
    logic        ClrReq = 1'b0;

    logic [15:0] rd_a0, rd_b0, rd_az, rd_bz;
    logic        va0, vb0, vaz, vbz, busy0, busyz;

    int checks = 0;
    int errors = 0;

    logic [15:0] m0 [8];
    logic [15:0] mz [8];
    logic [15:0] ea0, eb0, eaz, ebz;
    logic        eva, evb;
    int          busy_left;

    always #5 CLK = ~CLK;

    reg_file_2r1w #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdEnB(RdEnB), .RdAddrB(RdAddrB),
        .RdDataA(rd_a0), .RdDataB(rd_b0), .RdValidA(va0), .RdValidB(vb0),
        .ClrReq(ClrReq), .Busy(busy0)
    );

    reg_file_2r1w #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut_z (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdEnB(RdEnB), .RdAddrB(RdAddrB),
        .RdDataA(rd_az), .RdDataB(rd_bz), .RdValidA(vaz), .RdValidB(vbz),
        .ClrReq(ClrReq), .Busy(busyz)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m0[i] = '0;
            mz[i] = '0;
        end
        ea0 = '0; eb0 = '0; eaz = '0; ebz = '0;
        eva = 1'b0; evb = 1'b0;
        busy_left = 0;
    endtask

    function automatic logic [15:0] mread(input bit zero, input logic [2:0] a);
        if (zero && a == 3'd0) return 16'h0000;
        if (WrEn && WrAddr == a) return WrData;
        return zero ? mz[a] : m0[a];
    endfunction

    // Clear is modelled as "everything is zero and the block is deaf for
    // DEPTH cycles"; contents are invisible until the sequence ends anyway.
    task automatic model_step();
        eva = 1'b0;
        evb = 1'b0;
        if (busy_left > 0) begin
            busy_left--;
        end else if (ClrReq) begin
            for (int i = 0; i < 8; i++) begin
                m0[i] = '0;
                mz[i] = '0;
            end
            busy_left = 8;
        end else begin
            if (RdEnA) begin
                eva = 1'b1; ea0 = mread(0, RdAddrA); eaz = mread(1, RdAddrA);
            end
            if (RdEnB) begin
                evb = 1'b1; eb0 = mread(0, RdAddrB); ebz = mread(1, RdAddrB);
            end
            if (WrEn) begin
                m0[WrAddr] = WrData;
                if (WrAddr != 3'd0) mz[WrAddr] = WrData;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy"},  32'(busy0), 32'(busy_left > 0));
        chk({tag, ".busyz"}, 32'(busyz), 32'(busy_left > 0));
        chk({tag, ".va"},    32'(va0),   32'(eva));
        chk({tag, ".vb"},    32'(vb0),   32'(evb));
        chk({tag, ".vaz"},   32'(vaz),   32'(eva));
        chk({tag, ".vbz"},   32'(vbz),   32'(evb));
        chk({tag, ".da"},    32'(rd_a0), 32'(ea0));
        chk({tag, ".db"},    32'(rd_b0), 32'(eb0));
        chk({tag, ".daz"},   32'(rd_az), 32'(eaz));
        chk({tag, ".dbz"},   32'(rd_bz), 32'(ebz));
    endtask

    task automatic cyc(input string tag, input logic we, input logic [2:0] wa,
                       input logic [15:0] wd, input logic rea, input logic [2:0] raa,
                       input logic reb, input logic [2:0] rab, input logic clr);
        WrEn = we; WrAddr = wa; WrData = wd;
        RdEnA = rea; RdAddrA = raa; RdEnB = reb; RdAddrB = rab; ClrReq = clr;
        @(posedge CLK);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int busy_cycles;

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        RST = 1'b1;

        // Single write then read.
        cyc("w5", 1, 5, 16'hBEEF, 0, 0, 0, 0, 0);
        cyc("r5", 0, 0, 0, 1, 5, 0, 0, 0);
        chk("req029.data", 32'(rd_a0), 32'h0000BEEF);
        chk("req029.valid", 32'(va0), 32'd1);
        idle("r5.after");
        chk("req029.pulse", 32'(va0), 32'd0);

        // Same-cycle write + bypass read + other-port read.
        cyc("w4", 1, 4, 16'h00AA, 0, 0, 0, 0, 0);
        cyc("byp", 1, 3, 16'h1234, 1, 3, 1, 4, 0);
        chk("req030.a", 32'(rd_a0), 32'h00001234);
        chk("req030.b", 32'(rd_b0), 32'h000000AA);

        // Entry 0: normal instance stores it, zero-reg instance ignores it.
        cyc("w0", 1, 0, 16'hFFFF, 0, 0, 0, 0, 0);
        cyc("r0", 0, 0, 0, 1, 0, 1, 0, 0);
        chk("req031.read", 32'(rd_az), 32'd0);
        cyc("w0byp", 1, 0, 16'hFFFF, 1, 0, 0, 0, 0);
        chk("req031.bypass", 32'(rd_az), 32'd0);
        chk("req031.plain", 32'(rd_a0), 32'h0000FFFF);

        // Hold when RdEn is low.
        cyc("w6", 1, 6, 16'h0F0F, 0, 0, 0, 0, 0);
        cyc("r6", 0, 0, 0, 1, 6, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc("hold", 1, 3'(i), 16'h7000 + 16'(i), 0, 0, 0, 0, 0);
            chk("req034.data", 32'(rd_a0), 32'h00000F0F);
        end

        // Fill, clear, poke during busy, read back zeros.
        for (int i = 0; i < 8; i++) cyc("fill", 1, 3'(i), 16'h1111 * 16'(i + 1), 0, 0, 0, 0, 0);
        cyc("clr", 1, 2, 16'hDEAD, 1, 2, 1, 3, 1);
        busy_cycles = 0;
        for (int i = 0; i < 20 && busy0; i++) begin
            busy_cycles++;
            cyc("busy", 1, 3'(i), 16'hCAFE, 1, 3'(i), 1, 3'(i + 1), 1);
        end
        chk("req032.busylen", 32'(busy_cycles), 32'd8);
        for (int i = 0; i < 8; i++) cyc("clrrd", 0, 0, 0, 1, 3'(i), 1, 3'(7 - i), 0);

        // Reset in the middle of a clear.
        for (int i = 1; i < 8; i++) cyc("fill2", 1, 3'(i), 16'hA000 + 16'(i), 0, 0, 0, 0, 0);
        cyc("clr2", 0, 0, 0, 0, 0, 0, 0, 1);
        idle("clr2.1");
        idle("clr2.2");
        #2 RST = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        WrEn = 0; RdEnA = 0; RdEnB = 0; ClrReq = 0;
        @(posedge CLK);
        #3 RST = 1'b1;
        cyc("rst.w7", 1, 7, 16'h5A5A, 0, 0, 0, 0, 0);
        cyc("rst.r7", 0, 0, 0, 1, 7, 0, 0, 0);
        chk("req033.r7", 32'(rd_a0), 32'h00005A5A);
        for (int i = 0; i < 7; i++) cyc("rst.rd", 0, 0, 0, 1, 3'(i), 1, 3'(6 - i), 0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            cyc("rand", 1'($urandom_range(1)), 3'($urandom_range(7)), 16'($urandom),
                1'($urandom_range(1)), 3'($urandom_range(7)),
                1'($urandom_range(1)), 3'($urandom_range(7)),
                1'($urandom_range(39) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
